vh_result_unpacker: RTL
=======================

# vh_result_unpacker

Receive-side companion to the vloghammer expression blocks. Accepts one packed 90-bit result vector `y = {y0..y17}` per handshake, splits it into its 18 fields, and emits them one per cycle as extended 8-bit values. Each emitted field is folded into a running 32-bit signature, so the regression harness compares one word per run instead of raw vectors.

## Interface
- `W_SIG`: default 32. Signature width; must be ≥ 8.
- `clk`: input, 1 bit. Single clock; all state is updated on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `in_valid`: input, 1 bit. A result vector is presented on `in_y`.
- `in_ready`: output, 1 bit. The block can accept a vector.
- `in_y`: input, 90 bits. Packed vector `{y0,...,y17}`; `y0` occupies bits [89:86].
- `out_valid`: output, 1 bit. A field is presented on the output.
- `out_ready`: input, 1 bit. Downstream accepts the field.
- `out_idx`: output, 5 bits. Field index, 0..17.
- `out_data`: output, 8 bits. Field value, extended to 8 bits.
- `out_last`: output, 1 bit. High when `out_idx` = 17.
- `sig_clr`: input, 1 bit. Synchronous clear of the signature and the vector count.
- `sig`: output, `W_SIG` bits. Running signature.
- `sig_done`: output, 1 bit. One-cycle pulse after the final field of a vector is accepted.
- `vec_count`: output, 16 bits. Number of vectors completed; wraps at 16 bits.

## Operation
- **Field layout.** Field k has width `4 + (k mod 3)`.
  - Fields with `(k mod 6) < 3` are unsigned; all others are signed.
  - Fields pack MSB-first, contiguous. `y17` is at [5:0], `y16` at [10:6], `y15` at [14:11], `y14` at [20:15], and so on up to `y0` at [89:86].
- **Extension.** Unsigned fields are zero-extended to 8 bits; signed fields are sign-extended.
- **States.**
  - `IDLE`: `in_ready` = 1. On `in_valid`, capture `in_y` into an internal 90-bit register, set idx = 0, and go to `EMIT`.
  - `EMIT`: `out_valid` = 1. On an output handshake (`out_valid && out_ready`):
    - if idx < 17, increment idx;
    - if idx = 17, return to `IDLE`.
- **Back-to-back limit.** `in_ready` is 0 throughout `EMIT`, so a new vector is never accepted while one is being emitted.
- **Signature update.** On each output handshake: `sig <= {sig[W_SIG-2:0], sig[W_SIG-1]} ^ zero-extend(out_data)`.
- **End of vector.** On the idx = 17 handshake, `vec_count` increments (wraps 0xFFFF→0) and `sig_done` pulses on the following cycle.
- **`sig_clr` priority.** `sig_clr` forces `sig` and `vec_count` to 0 and takes priority over a same-cycle update, whose contribution is dropped. `sig_clr` does not affect the FSM, idx, the captured vector, or `sig_done`.
- **Backpressure.** While `out_ready` = 0, `out_idx`, `out_data` and `out_last` hold stable and `sig` is unchanged.

## Timing
- **Reset values.**
  - State `IDLE`.
  - `in_ready` = 1.
  - `out_valid`, `out_last`, `sig_done` = 0.
  - `out_idx`, `out_data` = 0.
  - `sig` and `vec_count` = 0.
- **Combinational paths.** Outputs are functions of registered state only; there is no combinational path from `out_ready` or `in_valid` to any output.
- **Latency.** An input handshake at cycle N gives `out_valid` = 1 with idx 0 at cycle N+1.
- **Throughput.** With `out_ready` held high, field 17 handshakes at N+18, `sig_done` is high in N+19, and `in_ready` returns high in N+19. Minimum period is 19 cycles per vector.
- **Reset mid-operation.** Asserting `rst_n` low during `EMIT` aborts the vector immediately. No `sig_done` is generated and `vec_count` is not incremented.

## Test plan
- **Zero vector.** `in_y` = 0, `out_ready` = 1 → 18 fields with `out_data` = 0x00 and idx 0..17; `out_last` only at idx 17; `sig` = 0; `vec_count` = 1; one `sig_done` pulse at N+19.
- **Extension.** Only `y0` = 4'hF → idx 0 emits 0x0F. Only `y3` = 4'b1000 → idx 3 emits 0xF8. Only `y17` = 6'h3F → idx 17 emits 0xFF and final `sig` = 0x000000FF.
- **Signature rotation.** Only `y0` = 4'h1 → final `sig` = 0x00020000. A second identical vector without `sig_clr` → `sig` = 0x00020000 rotated 18 and XORed per field = 0x00000008 ^ 0x00020000… check against the reference model; `vec_count` = 2.
- **Backpressure.** Toggle `out_ready` pseudo-randomly on a random vector → `out_data`/`out_idx` stable while stalled; field sequence and `sig` identical to the no-stall run; `in_ready` = 0 until the final handshake.
- **Clear collision.** Assert `sig_clr` in the same cycle as the idx-17 handshake → `sig` = 0, `vec_count` = 0, `sig_done` still pulses, FSM returns to `IDLE`.
- **Reset mid-vector.** Pulse `rst_n` low at idx 7 → all outputs return to their reset values asynchronously; the next vector emits from idx 0 with `sig` starting at 0.

Source files
------------

// File: rtl/vh_result_unpacker.sv
// Splits a packed 90-bit result vector into 18 extended fields, one per cycle, folding each into a signature.
// Latency: input handshake at N gives field 0 at N+1; 19 cycles per vector with out_ready high.
// Backpressure: out_ready low holds the current field and signature; in_ready stays low until field 17 is accepted.
module vh_result_unpacker #(
  parameter int W_SIG = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [89:0]      in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_idx,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             sig_clr,
  output logic [W_SIG-1:0] sig,
  output logic             sig_done,
  output logic [15:0]      vec_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [89:0]      vec_q;
  logic [4:0]       idx_q;
  logic [W_SIG-1:0] sig_q;
  logic [15:0]      cnt_q;
  logic             done_q;
  logic [7:0]       ext [18];
  logic [7:0]       sel;
  logic             in_hs, out_hs, last_hs;

  // Fields are packed MSB-first, so field k sits above the widths of all later fields.
  function automatic int field_lsb(input int k);
    int s;
    s = 0;
    for (int j = k + 1; j < 18; j++) s += 4 + (j % 3);
    return s;
  endfunction

  for (genvar k = 0; k < 18; k++) begin : g_fld
    localparam int W   = 4 + (k % 3);
    localparam int LSB = field_lsb(k);
    localparam bit SGN = (k % 6) >= 3;
    logic [W-1:0] raw;
    assign raw    = vec_q[LSB +: W];
    assign ext[k] = SGN ? {{(8-W){raw[W-1]}}, raw} : {{(8-W){1'b0}}, raw};
  end

  always_comb begin
    sel = 8'h00;
    for (int k = 0; k < 18; k++) begin
      if (idx_q == 5'(k)) sel = ext[k];
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = out_valid ? idx_q : 5'd0;
  assign out_data  = out_valid ? sel : 8'h00;
  assign out_last  = out_valid && (idx_q == 5'd17);
  assign sig       = sig_q;
  assign sig_done  = done_q;
  assign vec_count = cnt_q;

  assign in_hs   = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign last_hs = out_hs && (idx_q == 5'd17);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EMIT;
      EMIT:    if (last_hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_hs;
      if (in_hs) begin
        vec_q <= in_y;
        idx_q <= '0;
      end else if (out_hs && !last_hs) begin
        idx_q <= idx_q + 5'd1;
      end
    end
  end

  // A clear wins over a same-cycle fold; the dropped field is intentionally lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
      cnt_q <= '0;
    end else if (sig_clr) begin
      sig_q <= '0;
      cnt_q <= '0;
    end else begin
      if (out_hs)  sig_q <= {sig_q[W_SIG-2:0], sig_q[W_SIG-1]} ^ W_SIG'(out_data);
      if (last_hs) cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule
